// File: rtl/sram_fill_sequencer.sv
// sram_fill_sequencer: one fill request -> DRAM line-fetch stream + per-chunk collector commands; SFS_PAD_EN adds pad chunks.
// Both streams registered, first beat 1 cycle after o_req_ack, 1 beat/cycle; each stream holds its payload until its own ack.
module sram_fill_sequencer #(
   parameter int GBW   = 32,
   parameter int LBW   = 10,
   parameter int CSIZE = 32,
   parameter int VSIZE = 32,
   localparam int CC_BW  = $clog2(CSIZE),
   localparam int CV_BW1 = $clog2(VSIZE + 1)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_req_rdy,
   output logic                 o_req_ack,
   input  logic [GBW-1:0]       i_req_gaddr,
   input  logic [LBW:0]         i_req_len,
`ifdef SFS_PAD_EN
   input  logic [LBW:0]         i_req_lpad,
   input  logic [LBW:0]         i_req_rpad,
`endif
   output logic                 o_dram_rdy,
   input  logic                 i_dram_ack,
   output logic [GBW-CC_BW-1:0] o_dram_laddr,
   output logic                 o_cmd_rdy,
   input  logic                 i_cmd_ack,
   output logic [1:0]           o_cmd_type,
   output logic                 o_cmd_islast,
   output logic [CC_BW-1:0]     o_cmd_addrofs,
   output logic [CV_BW1-1:0]    o_cmd_len
);

   localparam int RW = LBW + 1;
   localparam int LW = GBW - CC_BW;
   localparam logic [RW-1:0] VS_R = RW'(VSIZE);
   localparam logic [RW-1:0] CS_R = RW'(CSIZE);

`ifdef SFS_PAD_EN
   typedef enum logic [1:0] {C_IDLE, C_LPAD, C_DATA, C_RPAD} cst_t;
`else
   typedef enum logic [0:0] {C_IDLE, C_DATA} cst_t;
`endif
   typedef enum logic {L_IDLE, L_ISSUE} lst_t;

   cst_t              r_cst, w_cst_nxt, w_ph, w_nph;
   lst_t              r_lst, w_lst_nxt;
   logic [RW-1:0]     r_data_rem, w_dl, w_dl_nxt;
   logic [GBW-1:0]    r_cur_gaddr, w_ga, w_ga_nxt;
   logic              r_cmd_rdy, r_cmd_islast;
   logic [CC_BW-1:0]  r_cmd_addrofs, w_ofs, w_aofs;
   logic [CV_BW1-1:0] r_cmd_len;
   logic [RW-1:0]     w_room, w_dmin, w_len;
   logic              w_last, w_load, w_accept;
   logic [LW-1:0]     r_dram_laddr, r_line_last, w_first, w_lline;
   logic [GBW-1:0]    w_lend;
`ifdef SFS_PAD_EN
   logic [RW-1:0]     r_lpad_rem, r_rpad_rem, w_lp, w_rp, w_lp_nxt, w_rp_nxt;
   logic [1:0]        r_cmd_type, w_type;
`endif

   // Both streams must have fully drained before a new request is taken.
   assign w_accept  = i_rst && i_req_rdy && (r_cst == C_IDLE) && !r_cmd_rdy && (r_lst == L_IDLE);
   assign o_req_ack = w_accept;

   always_comb begin
      w_ph = r_cst;
      w_dl = r_data_rem;
      w_ga = r_cur_gaddr;
`ifdef SFS_PAD_EN
      w_lp = r_lpad_rem;
      w_rp = r_rpad_rem;
`endif
      // On accept the first chunk is computed straight from the request so it lands one cycle later.
      if (w_accept) begin
         w_dl = i_req_len;
         w_ga = i_req_gaddr;
`ifdef SFS_PAD_EN
         w_lp = i_req_lpad;
         w_rp = i_req_rpad;
         if (w_lp != '0)      w_ph = C_LPAD;
         else if (w_dl != '0) w_ph = C_DATA;
         else if (w_rp != '0) w_ph = C_RPAD;
         else                 w_ph = C_IDLE;
`else
         w_ph = (w_dl != '0) ? C_DATA : C_IDLE;
`endif
      end

      w_ofs    = w_ga[CC_BW-1:0];
      w_room   = CS_R - RW'(w_ofs);
      w_dmin   = (w_dl < w_room) ? w_dl : w_room;
      w_len    = '0;
      w_last   = 1'b0;
      w_aofs   = '0;
      w_nph    = w_ph;
      w_dl_nxt = w_dl;
      w_ga_nxt = w_ga;
`ifdef SFS_PAD_EN
      w_type   = 2'd0;
      w_lp_nxt = w_lp;
      w_rp_nxt = w_rp;
`endif
      case (w_ph)
`ifdef SFS_PAD_EN
         C_LPAD: begin
            w_len    = (w_lp < VS_R) ? w_lp : VS_R;
            w_type   = 2'd2;
            w_lp_nxt = w_lp - w_len;
            if (w_lp_nxt == '0)
               w_nph = (w_dl != '0) ? C_DATA : ((w_rp != '0) ? C_RPAD : C_IDLE);
         end
         C_RPAD: begin
            w_len    = (w_rp < VS_R) ? w_rp : VS_R;
            w_type   = 2'd2;
            w_rp_nxt = w_rp - w_len;
            if (w_rp_nxt == '0) w_nph = C_IDLE;
         end
`endif
         C_DATA: begin
            w_len    = (w_dmin < VS_R) ? w_dmin : VS_R;
            w_aofs   = w_ofs;
            w_last   = (w_len == w_room) || (w_len == w_dl);
            w_dl_nxt = w_dl - w_len;
            w_ga_nxt = w_ga + GBW'(w_len);
`ifdef SFS_PAD_EN
            if (w_dl_nxt == '0) w_nph = (w_rp != '0) ? C_RPAD : C_IDLE;
`else
            if (w_dl_nxt == '0) w_nph = C_IDLE;
`endif
         end
         default: w_nph = C_IDLE;
      endcase

      w_load    = (w_ph != C_IDLE) && (!r_cmd_rdy || i_cmd_ack);
      w_cst_nxt = w_load ? w_nph : r_cst;
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) r_cst <= C_IDLE;
      else        r_cst <= w_cst_nxt;
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_data_rem    <= '0;
         r_cur_gaddr   <= '0;
         r_cmd_rdy     <= 1'b0;
         r_cmd_islast  <= 1'b0;
         r_cmd_addrofs <= '0;
         r_cmd_len     <= '0;
`ifdef SFS_PAD_EN
         r_lpad_rem    <= '0;
         r_rpad_rem    <= '0;
         r_cmd_type    <= 2'd0;
`endif
      end else if (w_load) begin
         r_data_rem    <= w_dl_nxt;
         r_cur_gaddr   <= w_ga_nxt;
         r_cmd_rdy     <= 1'b1;
         r_cmd_islast  <= w_last;
         r_cmd_addrofs <= w_aofs;
         r_cmd_len     <= CV_BW1'(w_len);
`ifdef SFS_PAD_EN
         r_lpad_rem    <= w_lp_nxt;
         r_rpad_rem    <= w_rp_nxt;
         r_cmd_type    <= w_type;
`endif
      end else if (i_cmd_ack) begin
         r_cmd_rdy <= 1'b0;
      end
   end

   assign o_cmd_rdy     = r_cmd_rdy;
   assign o_cmd_islast  = r_cmd_islast;
   assign o_cmd_addrofs = r_cmd_addrofs;
   assign o_cmd_len     = r_cmd_len;
`ifdef SFS_PAD_EN
   assign o_cmd_type    = r_cmd_type;
`else
   assign o_cmd_type    = 2'd0;
`endif

   // Line range wraps with the word address.
   assign w_first = LW'(i_req_gaddr >> CC_BW);
   assign w_lend  = i_req_gaddr + GBW'(i_req_len) - GBW'(1);
   assign w_lline = LW'(w_lend >> CC_BW);

   always_comb begin
      w_lst_nxt = r_lst;
      case (r_lst)
         L_IDLE:  if (w_accept && (i_req_len != '0)) w_lst_nxt = L_ISSUE;
         L_ISSUE: if (i_dram_ack && (r_dram_laddr == r_line_last)) w_lst_nxt = L_IDLE;
         default: w_lst_nxt = L_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_lst        <= L_IDLE;
         r_dram_laddr <= '0;
         r_line_last  <= '0;
      end else begin
         r_lst <= w_lst_nxt;
         if (r_lst == L_IDLE) begin
            if (w_lst_nxt == L_ISSUE) begin
               r_dram_laddr <= w_first;
               r_line_last  <= w_lline;
            end
         end else if (i_dram_ack && (w_lst_nxt == L_ISSUE)) begin
            r_dram_laddr <= r_dram_laddr + LW'(1);
         end
      end
   end

   assign o_dram_rdy   = (r_lst == L_ISSUE);
   assign o_dram_laddr = r_dram_laddr;

endmodule

// File: tb/tb_sram_fill_sequencer.sv
// Scoreboard bench for sram_fill_sequencer: directed requests push hand-computed lines/commands, a monitor pops on each handshake.
`timescale 1ns/1ps
module tb_sram_fill_sequencer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_rdy = 1'b0;
   logic        req_ack;
   logic [31:0] req_gaddr = '0;
   logic [10:0] req_len = '0;
   logic [10:0] req_lpad = '0;
   logic [10:0] req_rpad = '0;
   logic        dram_rdy;
   logic        dram_ack = 1'b1;
   logic [26:0] dram_laddr;
   logic        cmd_rdy;
   logic        cmd_ack = 1'b1;
   logic [1:0]  cmd_type;
   logic        cmd_islast;
   logic [4:0]  cmd_addrofs;
   logic [5:0]  cmd_len;

   always #5 clk = ~clk;

   sram_fill_sequencer #(.GBW(32), .LBW(10), .CSIZE(32), .VSIZE(32)) dut (
      .i_clk(clk), .i_rst(rst_n),
      .i_req_rdy(req_rdy), .o_req_ack(req_ack),
      .i_req_gaddr(req_gaddr), .i_req_len(req_len),
`ifdef SFS_PAD_EN
      .i_req_lpad(req_lpad), .i_req_rpad(req_rpad),
`endif
      .o_dram_rdy(dram_rdy), .i_dram_ack(dram_ack), .o_dram_laddr(dram_laddr),
      .o_cmd_rdy(cmd_rdy), .i_cmd_ack(cmd_ack), .o_cmd_type(cmd_type),
      .o_cmd_islast(cmd_islast), .o_cmd_addrofs(cmd_addrofs), .o_cmd_len(cmd_len)
   );

   logic [13:0] exp_cmd[$];
   logic [26:0] exp_line[$];
   int n_pass = 0;
   int n_total = 0;

   wire [13:0] cur_cmd = {cmd_type, cmd_islast, cmd_addrofs, cmd_len};
   wire [43:0] all_outs = {req_ack, dram_rdy, dram_laddr, cmd_rdy, cmd_type, cmd_islast, cmd_addrofs, cmd_len};

   function automatic logic [13:0] mk(input logic [1:0] t, input logic [4:0] o, input logic [5:0] l, input logic last);
      return {t, last, o, l};
   endfunction

   task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Monitor: pop on every handshake, and require payload to hold across a stalled cycle.
   logic        pc_stall = 1'b0, pl_stall = 1'b0;
   logic [13:0] pc_val = '0;
   logic [26:0] pl_val = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         pc_stall = 1'b0;
         pl_stall = 1'b0;
      end else begin
         if (pc_stall) check(cmd_rdy && (cur_cmd == pc_val), "cmd_hold", {cmd_rdy, cur_cmd}, {1'b1, pc_val});
         if (pl_stall) check(dram_rdy && (dram_laddr == pl_val), "line_hold", {dram_rdy, dram_laddr}, {1'b1, pl_val});
         if (cmd_rdy && cmd_ack) begin
            if (exp_cmd.size() == 0) check(1'b0, "cmd_unexpected", cur_cmd, 0);
            else begin
               logic [13:0] e;
               e = exp_cmd.pop_front();
               check(cur_cmd == e, "cmd", cur_cmd, e);
            end
         end
         if (dram_rdy && dram_ack) begin
            if (exp_line.size() == 0) check(1'b0, "line_unexpected", dram_laddr, 0);
            else begin
               logic [26:0] e;
               e = exp_line.pop_front();
               check(dram_laddr == e, "line", dram_laddr, e);
            end
         end
         pc_stall = cmd_rdy && !cmd_ack;
         pc_val   = cur_cmd;
         pl_stall = dram_rdy && !dram_ack;
         pl_val   = dram_laddr;
      end
   end

   task automatic req(input logic [31:0] ga, input logic [10:0] ln, input logic [10:0] lp, input logic [10:0] rp,
                      input bit cmd_any, input bit line_any);
      bit got;
      @(posedge clk); #1;
      req_rdy = 1'b1; req_gaddr = ga; req_len = ln; req_lpad = lp; req_rpad = rp;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (req_ack) got = 1'b1;
      end
      check(got, "req_ack", {63'd0, got}, 1);
      @(posedge clk); #1;
      req_rdy = 1'b0;
      check(cmd_rdy == cmd_any, "cmd_rdy_latency", {63'd0, cmd_rdy}, {63'd0, cmd_any});
      check(dram_rdy == line_any, "dram_rdy_latency", {63'd0, dram_rdy}, {63'd0, line_any});
   endtask

   task automatic drain(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         done = (exp_cmd.size() == 0) && (exp_line.size() == 0) && !cmd_rdy && !dram_rdy;
      end
      check(done, name, exp_cmd.size() + exp_line.size(), 0);
   endtask

   task automatic push_unaligned();
      exp_line.push_back(27'h2); exp_line.push_back(27'h3);
      exp_cmd.push_back(mk(2'd0, 5'd5, 6'd27, 1'b1));
      exp_cmd.push_back(mk(2'd0, 5'd0, 6'd13, 1'b1));
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check(all_outs == '0, "reset_state", all_outs, 0);
      rst_n = 1'b1;

      // Aligned single line, rdy drops right after the handshake.
      exp_line.push_back(27'h2);
      exp_cmd.push_back(mk(2'd0, 5'd0, 6'd32, 1'b1));
      req(32'h40, 11'd32, 11'd0, 11'd0, 1'b1, 1'b1);
      @(posedge clk); #1;
      check(cmd_rdy == 1'b0, "cmd_rdy_drop", {63'd0, cmd_rdy}, 0);
      drain("aligned_drain");

      push_unaligned();
      req(32'h45, 11'd40, 11'd0, 11'd0, 1'b1, 1'b1);
      drain("unaligned_drain");

`ifdef SFS_PAD_EN
      exp_line.push_back(27'h1); exp_line.push_back(27'h2);
      exp_cmd.push_back(mk(2'd2, 5'd0, 6'd3, 1'b0));
      exp_cmd.push_back(mk(2'd0, 5'd30, 6'd2, 1'b1));
      exp_cmd.push_back(mk(2'd0, 5'd0, 6'd2, 1'b1));
      exp_cmd.push_back(mk(2'd2, 5'd0, 6'd32, 1'b0));
      exp_cmd.push_back(mk(2'd2, 5'd0, 6'd8, 1'b0));
      req(32'h3E, 11'd4, 11'd3, 11'd40, 1'b1, 1'b1);
      drain("pad_drain");

      exp_cmd.push_back(mk(2'd2, 5'd0, 6'd5, 1'b0));
      req(32'h80, 11'd0, 11'd5, 11'd0, 1'b1, 1'b0);
      drain("zero_data_pad_drain");
`endif

      // Empty request: acked, nothing emitted.
      req(32'h80, 11'd0, 11'd0, 11'd0, 1'b0, 1'b0);
      drain("empty_drain");

      // Address wrap with the line stream stalled.
      dram_ack = 1'b0;
      exp_line.push_back(27'h7FF_FFFF); exp_line.push_back(27'h0);
      exp_cmd.push_back(mk(2'd0, 5'd24, 6'd8, 1'b1));
      exp_cmd.push_back(mk(2'd0, 5'd0, 6'd8, 1'b1));
      req(32'hFFFF_FFF8, 11'd16, 11'd0, 11'd0, 1'b1, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      check(dram_rdy && (dram_laddr == 27'h7FF_FFFF), "line_stall", {dram_rdy, dram_laddr}, {1'b1, 27'h7FF_FFFF});
      dram_ack = 1'b1;
      drain("wrap_drain");

      // Command backpressure: lines run ahead independently.
      cmd_ack = 1'b0;
      exp_line.push_back(27'h8); exp_line.push_back(27'h9); exp_line.push_back(27'hA);
      repeat (3) exp_cmd.push_back(mk(2'd0, 5'd0, 6'd32, 1'b1));
      req(32'h100, 11'd96, 11'd0, 11'd0, 1'b1, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      check(exp_line.size() == 0, "lines_run_ahead", exp_line.size(), 0);
      check(cmd_rdy && (exp_cmd.size() == 3), "cmd_stalled", {cmd_rdy, 32'(exp_cmd.size())}, {1'b1, 32'd3});
      cmd_ack = 1'b1;
      drain("backpressure_drain");

      // Reset while the second unaligned command is presented.
      exp_line.push_back(27'h2); exp_line.push_back(27'h3);
      exp_cmd.push_back(mk(2'd0, 5'd5, 6'd27, 1'b1));
      req(32'h45, 11'd40, 11'd0, 11'd0, 1'b1, 1'b1);
      @(posedge clk); #1;
      check(cmd_rdy && (cur_cmd == mk(2'd0, 5'd0, 6'd13, 1'b1)), "second_cmd_present",
            {cmd_rdy, cur_cmd}, {1'b1, mk(2'd0, 5'd0, 6'd13, 1'b1)});
      rst_n = 1'b0;
      #1;
      check(all_outs == '0, "reset_mid", all_outs, 0);
      exp_cmd.delete();
      exp_line.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      push_unaligned();
      req(32'h45, 11'd40, 11'd0, 11'd0, 1'b1, 1'b1);
      drain("replay_drain");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200us, expected finish");
      $fatal(1);
   end
endmodule
